xbar_rr_arbiter: RTL and testbench
==================================

# xbar_rr_arbiter

Registered, locking round-robin arbiter for one crossbar output port. It takes one request per source (master or slave side, depending on channel) and issues a one-hot grant. That grant gates the per-source payload vectors before the downstream AND/OR reduction stage, which collapses them to the single selected payload. A grant is held until the transaction owner signals completion, so multi-beat bursts are never interleaved.

## Interface
- NUM, 2: number of requesting sources; legal range 2..32.
- IDX_W, $clog2(NUM): width of the grant index; must be ≥1.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM  per-source request; bit i = source i has a pending transaction.
- done  input  1  current owner finished (e.g. last beat handshaked); sampled only in BUSY.
- gnt  output  NUM  registered one-hot grant; all-zero when idle.
- gnt_idx  output  IDX_W  binary index of the granted source; holds last value when idle.
- gnt_valid  output  1  high when gnt is non-zero.

## Operation
- State: IDLE, BUSY. Priority pointer `ptr` (IDX_W bits) = highest-priority source for the next arbitration.
- Arbitration: search req starting at ptr, ascending, wrapping NUM-1 → 0. The first set bit wins.
- IDLE:
  - any req set → BUSY; gnt/gnt_idx load the winner; ptr ← winner+1 (mod NUM).
  - no req → stay IDLE; outputs unchanged from idle values.
- BUSY:
  - done=0 → hold gnt, gnt_idx, ptr. Changes on req, including the owner dropping its request, are ignored (locked).
  - done=1 with any req set excluding the current owner's bit → re-arbitrate in the same cycle. The new grant is registered for the next cycle, ptr advances, state stays BUSY. There is no bubble.
  - done=1 with the owner's req still set and others set → the owner has the lowest priority, because ptr already moved past it.
  - done=1 with the owner the only requester → the owner is re-granted (same gnt, BUSY). ptr ← owner+1.
  - done=1 and req=0 → IDLE; gnt=0, gnt_valid=0.
- Wrap-around: ptr increment is modulo NUM, not modulo 2^IDX_W. For example, NUM=3, winner 2 → ptr 0.
- done in IDLE has no effect.
- Invariant: gnt is one-hot or zero; gnt_valid == |gnt; gnt[gnt_idx]==1 whenever gnt_valid.

## Timing
- Reset (rst=1 at an edge): state IDLE, gnt=0, gnt_idx=0, gnt_valid=0, ptr=0.
  - rst dominates all other inputs.
  - Reset mid-burst drops the grant on the next edge.
- Request-to-grant latency: 1 cycle. req rising at edge N is visible in gnt after edge N+1.
- Handover latency: done sampled at edge N → new owner's gnt visible after edge N. Each owner keeps gnt for ≥1 cycle.
- All outputs are driven directly from flops. There is no combinational path from req or done to any output.

## Configuration
- XBAR_ARB_RR_EN defined: round-robin as described above.
- XBAR_ARB_RR_EN undefined: fixed priority. ptr is removed and tied to 0, so the lowest requesting index always wins. Locking, latency and reset behaviour are unchanged.

## Test plan
- Reset/idle: rst for 2 cycles, then req=0 for 5 cycles → gnt=0, gnt_valid=0, gnt_idx=0 throughout.
- Single grant, NUM=4 (RR): req=4'b0100 at cycle 0 → cycle 1 gnt=4'b0100, gnt_idx=2. Hold done=0 for 3 cycles while req drops to 0 → gnt stays 4'b0100. Then done=1 → next cycle gnt=0, gnt_valid=0.
- Fairness, NUM=4 (RR): req=4'b1111 held; pulse done every 2nd cycle → grant order 0,1,2,3,0 with no idle cycle between owners.
- Wrap/modulo, NUM=3 (RR): req=3'b100 then done with req=3'b101 → next owner 0 (ptr wrapped 2→0), not 2.
- Sole requester re-grant: NUM=4 owner 1, req=4'b0010, done=1 → gnt remains 4'b0010, gnt_valid stays high, ptr=2.
- Fixed priority (XBAR_ARB_RR_EN undefined): req=4'b1111 with repeated done → grant always 4'b0001. Assert rst mid-grant → gnt=0 after that edge.

Source files
------------

// File: rtl/xbar_rr_arbiter_if.sv
// Request/grant bundle between the crossbar sources and one output-port arbiter.
// The arbiter uses the slave view; the request side uses the master view.
interface xbar_rr_arbiter_if #(
  parameter int NUM   = 2,
  parameter int IDX_W = $clog2(NUM)
) ();

  logic [NUM-1:0]   req;
  logic             done;
  logic [NUM-1:0]   gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );

endinterface

// File: rtl/xbar_rr_arbiter.sv
// Registered, locking arbiter for one crossbar output port.
// Define XBAR_ARB_RR_EN for round-robin priority; otherwise fixed priority (lowest index wins).
module xbar_rr_arbiter #(
  parameter int NUM   = 2,
  parameter int IDX_W = $clog2(NUM)
) (
  input  logic              clk,
  input  logic              rst,
  xbar_rr_arbiter_if.slave  bus
);

  if (NUM < 2 || NUM > 32) begin : g_num_check
    $error("xbar_rr_arbiter: NUM must be in 2..32");
  end
  if (IDX_W < 1 || (2 ** IDX_W) < NUM) begin : g_idx_check
    $error("xbar_rr_arbiter: IDX_W too narrow for NUM");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [NUM-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [NUM-1:0]   win_onehot;
  logic             load;

`ifdef XBAR_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
`else
  localparam logic [IDX_W-1:0] ptr_q = '0;
`endif

  // Index arithmetic wraps at NUM, which need not be a power of two.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned       off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM) sum = sum - NUM;
    return sum[IDX_W-1:0];
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM; k++) begin
      if (!win_found && bus.req[wrap_add(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  assign win_onehot = NUM'(1) << win_idx;

  // Requests are only looked at in IDLE or on the owner's done cycle, which gives the burst lock.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    load    = 1'b0;
`ifdef XBAR_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          load = 1'b1;
        end
      end
      BUSY: begin
        if (bus.done) begin
          if (win_found) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
    if (load) begin
      state_d = BUSY;
      gnt_d   = win_onehot;
      idx_d   = win_idx;
      valid_d = 1'b1;
`ifdef XBAR_ARB_RR_EN
      ptr_d   = wrap_add(win_idx, 1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
`ifdef XBAR_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
`ifdef XBAR_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Directed plus short random bench for xbar_rr_arbiter at NUM=4 and NUM=3.
// Follows the XBAR_ARB_RR_EN build choice so both priority modes are checked.
module tb_xbar_rr_arbiter;

  logic clk;
  logic rst;

  xbar_rr_arbiter_if #(.NUM(4), .IDX_W(2)) b4 ();
  xbar_rr_arbiter_if #(.NUM(3), .IDX_W(2)) b3 ();

  xbar_rr_arbiter #(.NUM(4), .IDX_W(2)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  xbar_rr_arbiter #(.NUM(3), .IDX_W(2)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit busy;
    int ptr;
    int idx;
    bit valid;
  } mdl_t;

  typedef struct {
    logic [3:0] g4;
    logic [1:0] i4;
    logic       v4;
    logic [2:0] g3;
    logic [1:0] i3;
    logic       v3;
  } exp_t;

  mdl_t m4, m3;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural reference: scan from the priority start and wrap with the modulo operator.
  function automatic mdl_t model_next(input mdl_t m, input int num, input logic [31:0] r,
                                      input bit d, input bit rs);
    mdl_t n;
    int   w;
    int   start;
    n = m;
    w = -1;
`ifdef XBAR_ARB_RR_EN
    start = m.ptr;
`else
    start = 0;
`endif
    if (rs) begin
      n.busy = 0; n.ptr = 0; n.idx = 0; n.valid = 0;
      return n;
    end
    if (!m.busy || d) begin
      for (int k = 0; k < num; k++) begin
        if (w < 0 && r[(start + k) % num] === 1'b1) w = (start + k) % num;
      end
      if (w >= 0) begin
        n.busy = 1; n.idx = w; n.valid = 1; n.ptr = (w + 1) % num;
      end else if (m.busy) begin
        n.busy = 0; n.valid = 0;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    check("gnt4",       32'(b4.gnt),       32'(e.g4));
    check("gnt_idx4",   32'(b4.gnt_idx),   32'(e.i4));
    check("gnt_valid4", 32'(b4.gnt_valid), 32'(e.v4));
    check("gnt3",       32'(b3.gnt),       32'(e.g3));
    check("gnt_idx3",   32'(b3.gnt_idx),   32'(e.i3));
    check("gnt_valid3", 32'(b3.gnt_valid), 32'(e.v3));
  endtask

  // One clock: drive at the falling edge, predict, then compare just after the rising edge.
  task automatic applyStimulus(input logic r, input logic [3:0] q4, input logic d4,
                               input logic [2:0] q3, input logic d3);
    exp_t e;
    @(negedge clk);
    rst     = r;
    b4.req  = q4;
    b4.done = d4;
    b3.req  = q3;
    b3.done = d3;
    m4 = model_next(m4, 4, 32'(q4), d4, r);
    m3 = model_next(m3, 3, 32'(q3), d3, r);
    e.g4 = m4.valid ? (4'd1 << m4.idx) : 4'd0;
    e.i4 = 2'(m4.idx);
    e.v4 = m4.valid;
    e.g3 = m3.valid ? (3'd1 << m3.idx) : 3'd0;
    e.i3 = 2'(m3.idx);
    e.v3 = m3.valid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    m4 = '{busy: 0, ptr: 0, idx: 0, valid: 0};
    m3 = '{busy: 0, ptr: 0, idx: 0, valid: 0};
    rst = 1'b1;
    b4.req = '0; b4.done = 1'b0;
    b3.req = '0; b3.done = 1'b0;

    // Reset, idle, and done while idle
    repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
    repeat (5) applyStimulus(1'b0, 4'b0000, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 3'b000, 1'b1);
    check("idle_gnt", 32'(b4.gnt), 32'd0);

    // Single grant with lock while the owner drops its request
    applyStimulus(1'b0, 4'b0100, 1'b0, 3'b000, 1'b0);
    check("single_gnt", 32'(b4.gnt), 32'h4);
    check("single_idx", 32'(b4.gnt_idx), 32'd2);
    repeat (3) applyStimulus(1'b0, 4'b0000, 1'b0, 3'b000, 1'b0);
    check("locked_gnt", 32'(b4.gnt), 32'h4);
    applyStimulus(1'b0, 4'b0000, 1'b1, 3'b000, 1'b0);
    check("release_valid", 32'(b4.gnt_valid), 32'd0);

    // Fairness: all request, done every second cycle
    applyStimulus(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0, 3'b000, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b1, 3'b000, 1'b0);
    end
`ifdef XBAR_ARB_RR_EN
    check("fair_wrap_idx", 32'(b4.gnt_idx), 32'd0);
`else
    check("fixed_idx", 32'(b4.gnt), 32'h1);
`endif

    // Modulo wrap at NUM=3
    applyStimulus(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 3'b100, 1'b0);
    check("wrap_first", 32'(b3.gnt_idx), 32'd2);
    applyStimulus(1'b0, 4'b0000, 1'b0, 3'b101, 1'b1);
    check("wrap_next", 32'(b3.gnt_idx), 32'd0);

    // Sole requester re-grant, then priority after it
    applyStimulus(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b0, 4'b0010, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b0, 4'b0010, 1'b1, 3'b000, 1'b0);
    check("regrant_gnt", 32'(b4.gnt), 32'h2);
    check("regrant_valid", 32'(b4.gnt_valid), 32'd1);
    applyStimulus(1'b0, 4'b1111, 1'b1, 3'b000, 1'b0);
`ifdef XBAR_ARB_RR_EN
    check("after_regrant", 32'(b4.gnt_idx), 32'd2);
`else
    check("after_regrant", 32'(b4.gnt_idx), 32'd0);
`endif

    // Reset mid-grant
    applyStimulus(1'b0, 4'b1111, 1'b0, 3'b011, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 3'b011, 1'b1);
    check("rst_mid_gnt", 32'(b4.gnt), 32'd0);
    check("rst_mid_gnt3", 32'(b3.gnt), 32'd0);

    // Random traffic against the reference
    for (int i = 0; i < 60; i++) begin
      applyStimulus(logic'($urandom_range(0, 24) == 0),
                    4'($urandom_range(0, 15)), logic'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)),  logic'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
